// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: expands one cipher key into eleven round keys, one round
// key per clock, and serves them through a combinational indexed read port.
module aes_key_expand_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int unsigned NumKeys = 11;
  localparam logic [3:0]  LastRound = 4'd10;

  // AES forward S-box, entry 0 in the most significant byte of the first row.
  localparam logic [0:255][7:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {StIdle, StExpand} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return Sbox[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  state_e       state_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic [127:0] rk_q [NumKeys];

  logic [127:0] prev_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  // Select the previous round key; guarded so idle round values never index out of range.
  always_comb begin
    prev_key = '0;
    if (round_q >= 4'd1 && round_q <= LastRound) begin
      prev_key = rk_q[round_q - 4'd1];
    end
  end

  // One round of the key schedule: RotWord, SubWord, Rcon, then the chained XOR of words.
  always_comb begin
    w0       = prev_key[127:96];
    w1       = prev_key[95:64];
    w2       = prev_key[63:32];
    w3       = prev_key[31:0];
    rot_w    = {w3[23:0], w3[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    t_w      = sub_w ^ {rcon_q, 24'h0};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Control FSM with registered handshake outputs and the round-key register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      round_q   <= 4'd0;
      rcon_q    <= 8'h01;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i < NumKeys; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rk_q[0]   <= key_in;
            round_q   <= 4'd1;
            rcon_q    <= 8'h01;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state_q   <= StExpand;
          end
        end
        StExpand: begin
          rk_q[round_q] <= next_key;
          round_q       <= round_q + 4'd1;
          rcon_q        <= xtime(rcon_q);
          if (round_q == LastRound) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

  // Combinational read port; indices past the last round key read as zero.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= LastRound) begin
      rd_key = rk_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;
    #1 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    tick();
    vectors++;
    if ({busy, done, key_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/valid=%b want 000", {busy, done, key_valid});
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== '0) begin
        miscompares++;
        $display("FAIL reset_rd_key[%0d]: got %h want 0", i, rd_key);
      end
    end
  endtask

  task automatic test_fips();
    int  n    = 0;
    bit  seen = 0;
    key_in = FipsKey;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = '1;
    vectors++;
    if ({busy, key_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL fips_busy_after_e0: got busy/valid=%b want 10", {busy, key_valid});
    end
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (done) begin
        seen = 1;
        n    = c;
      end
    end
    vectors++;
    if (!seen || n != 10) begin
      miscompares++;
      $display("FAIL fips_done_latency: got seen=%0d cycles=%0d want 10", seen, n);
    end
    vectors++;
    if ({busy, key_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL fips_flags_done: got busy/valid=%b want 01", {busy, key_valid});
    end
    rd_idx = 4'd0;
    #1;
    vectors++;
    if (rd_key !== FipsKey) begin
      miscompares++;
      $display("FAIL fips_rk0: got %h want %h", rd_key, FipsKey);
    end
    rd_idx = 4'd1;
    #1;
    vectors++;
    if (rd_key !== FipsRk1) begin
      miscompares++;
      $display("FAIL fips_rk1: got %h want %h", rd_key, FipsRk1);
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== FipsRk10) begin
      miscompares++;
      $display("FAIL fips_rk10: got %h want %h", rd_key, FipsRk10);
    end
    tick();
    vectors++;
    if ({done, key_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL fips_done_one_cycle: got done/valid=%b want 01", {done, key_valid});
    end
  endtask

  task automatic test_zero_key();
    bit seen = 0;
    key_in = '0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (done) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL zero_done_timeout: got no done want done");
    end
    rd_idx = 4'd1;
    #1;
    vectors++;
    if (rd_key !== ZeroRk1) begin
      miscompares++;
      $display("FAIL zero_rk1: got %h want %h", rd_key, ZeroRk1);
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== ZeroRk10) begin
      miscompares++;
      $display("FAIL zero_rk10: got %h want %h", rd_key, ZeroRk10);
    end
    rd_idx = 4'd11;
    #1;
    vectors++;
    if (rd_key !== '0) begin
      miscompares++;
      $display("FAIL zero_rd_idx11: got %h want 0", rd_key);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    int first  = 0;
    key_in = FipsKey;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    // Fourth busy cycle: present a different key that must be ignored.
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    for (int c = 5; c <= 24; c++) begin
      if (c > 5) tick();
      if (done) begin
        pulses++;
        if (first == 0) first = c - 1;
      end
    end
    vectors++;
    if (pulses != 1 || first != 10) begin
      miscompares++;
      $display("FAIL busy_start_done: got pulses=%0d at=%0d want 1 at 10", pulses, first);
    end
    rd_idx = 4'd0;
    #1;
    vectors++;
    if (rd_key !== FipsKey) begin
      miscompares++;
      $display("FAIL busy_start_rk0: got %h want %h", rd_key, FipsKey);
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== FipsRk10) begin
      miscompares++;
      $display("FAIL busy_start_rk10: got %h want %h", rd_key, FipsRk10);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    bit seen   = 0;
    key_in = FipsKey;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_busy_before: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, key_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got busy/done/valid=%b want 000", {busy, done, key_valid});
    end
    rd_idx = 4'd0;
    #1;
    vectors++;
    if (rd_key !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_rk0: got %h want 0", rd_key);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: got pulses=%0d busy=%b want 0 0", pulses, busy);
    end
    key_in = '0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (done) seen = 1;
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (!seen || key_valid !== 1'b1 || rd_key !== ZeroRk10) begin
      miscompares++;
      $display("FAIL mid_reset_restart: got seen=%0d valid=%b rk10=%h want 1 1 %h",
               seen, key_valid, rd_key, ZeroRk10);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n    = 0;
    bit seen = 0;
    key_in = '0;
    start  = 1'b1;
    tick();
    key_in = FipsKey;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (done) begin
        seen = 1;
        n    = c;
      end
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (!seen || n != 10 || key_valid !== 1'b1 || rd_key !== ZeroRk10) begin
      miscompares++;
      $display("FAIL b2b_first: got seen=%0d at=%0d valid=%b rk10=%h want 1 10 1 %h",
               seen, n, key_valid, rd_key, ZeroRk10);
    end
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, key_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy/done/valid=%b want 100", {busy, done, key_valid});
    end
    seen = 0;
    n    = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (key_valid) begin
        seen = 1;
        n    = c;
      end
    end
    vectors++;
    if (!seen || n != 10 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_valid_low: got seen=%0d low_cycles=%0d done=%b want 1 10 1",
               seen, n, done);
    end
    rd_idx = 4'd1;
    #1;
    vectors++;
    if (rd_key !== FipsRk1) begin
      miscompares++;
      $display("FAIL b2b_rk1: got %h want %h", rd_key, FipsRk1);
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== FipsRk10) begin
      miscompares++;
      $display("FAIL b2b_rk10: got %h want %h", rd_key, FipsRk10);
    end
    rd_idx = 4'd12;
    #1;
    vectors++;
    if (rd_key !== '0) begin
      miscompares++;
      $display("FAIL b2b_rd_idx12: got %h want 0", rd_key);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
